lut_arb_ctrl: RTL and testbench

LUT_ARB_CTRL -- requirements
Module: lut_arb_ctrl

---
 rtl/lut_arb_ctrl.sv | 131 +++++++++++++
 tb/tb_lut_arb_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lut_arb_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lut_arb_ctrl : table lookup shared by two requesters through a round-robin
//                arbiter with a one-deep response slot.   Rev 1.0
// ---------------------------------------------------------------------------
module lut_arb_ctrl #(
  parameter int N = 1,
  parameter int W = 2,
  parameter int E = 2
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [N-1:0]     cfg_addr,
  input  logic [E*W-1:0]   cfg_data,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_idx,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_idx,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [E*W-1:0]   rsp_data,
  output logic             busy
);

  localparam int DEPTH = 2 ** N;
  localparam int DW    = E * W;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_last;
  logic            r_rsp_id;
  logic [DW-1:0]   r_rsp_data;
  logic [DW-1:0]   r_table [DEPTH];

  logic            w_slot_free;
  logic            w_cfg_acc;
  logic            w_lk_open;
  logic            w_lk_acc;
  logic            w_win;
  logic [N-1:0]    w_win_idx;

  // Readies are gated by the reset input so they drop without a clock edge.
  always_comb begin
    w_slot_free = 1'b0;
    w_cfg_acc   = 1'b0;
    w_lk_open   = 1'b0;
    w_lk_acc    = 1'b0;
    w_win       = 1'b0;
    w_win_idx   = req0_idx;
    w_state_nxt = r_state;
    cfg_ready   = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;

    w_slot_free = (r_state == S_IDLE) || rsp_ready;
    w_cfg_acc   = ASYNCRESETN && cfg_valid && w_slot_free;
    w_lk_open   = ASYNCRESETN && w_slot_free && !cfg_valid;

    // On a tie the requester not granted last wins; r_last=1 favours req0.
    if (req0_valid && req1_valid) begin
      w_win = ~r_last;
    end else begin
      w_win = req1_valid;
    end
    w_win_idx = w_win ? req1_idx : req0_idx;
    w_lk_acc  = w_lk_open && (req0_valid || req1_valid);

    cfg_ready  = w_cfg_acc;
    req0_ready = w_lk_acc && !w_win;
    req1_ready = w_lk_acc && w_win;

    case (r_state)
      S_IDLE: begin
        if (w_lk_acc) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (w_lk_acc)       w_state_nxt = S_RESP;
        else if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_last     <= 1'b1;
      r_rsp_id   <= 1'b0;
      r_rsp_data <= '0;
    end else if (w_lk_acc) begin
      r_last     <= w_win;
      r_rsp_id   <= w_win;
      r_rsp_data <= r_table[w_win_idx];
    end
  end

  // No lookup is accepted in a write cycle, so reads never race a write.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else if (w_cfg_acc) begin
      r_table[cfg_addr] <= cfg_data;
    end
  end

  assign rsp_valid = (r_state == S_RESP);
  assign busy      = rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_lut_arb_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lut_arb_ctrl : directed self-checking bench for lut_arb_ctrl (N=1,W=2,E=2)
// ---------------------------------------------------------------------------
module tb_lut_arb_ctrl;

  logic       CLK;
  logic       ASYNCRESETN;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [0:0] cfg_addr;
  logic [3:0] cfg_data;
  logic       req0_valid;
  logic       req0_ready;
  logic [0:0] req0_idx;
  logic       req1_valid;
  logic       req1_ready;
  logic [0:0] req1_idx;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_data;
  logic       busy;

  int n_checks;
  int n_fail;

  lut_arb_ctrl #(.N(1), .W(2), .E(2)) dut (
    .CLK        (CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_idx   (req0_idx),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_idx   (req1_idx),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic test_reset();
    ASYNCRESETN = 1'b0;
    cfg_valid = 1'b1; cfg_addr = 1'b0; cfg_data = 4'h5;
    req0_valid = 1'b1; req0_idx = 1'b0;
    req1_valid = 1'b0; req1_idx = 1'b0;
    rsp_ready = 1'b1;
    #3;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id got=%b want=0", rsp_id); end
    n_checks++; if (rsp_data !== 4'h0) begin n_fail++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_ready got=%b want=0", cfg_ready); end
    n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req0_ready got=%b want=0", req0_ready); end
    repeat (2) @(posedge CLK);
    #1;
    cfg_valid = 1'b0; req0_valid = 1'b0;
    ASYNCRESETN = 1'b1;
  endtask

  task automatic test_first_lookup();
    req0_valid = 1'b1; req0_idx = 1'b1; rsp_ready = 1'b1;
    #1;
    n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL first_req0_ready got=%b want=1", req0_ready); end
    @(posedge CLK); #1;
    req0_valid = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL first_rsp_valid got=%b want=1", rsp_valid); end
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL first_rsp_id got=%b want=0", rsp_id); end
    n_checks++; if (rsp_data !== 4'h0) begin n_fail++; $display("FAIL first_rsp_data got=%h want=0", rsp_data); end
  endtask

  task automatic test_cfg_then_lookup();
    cfg_valid = 1'b1; cfg_addr = 1'b1; cfg_data = 4'h9;
    #1;
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL cfg_ready_c0 got=%b want=1", cfg_ready); end
    @(posedge CLK); #1;
    cfg_valid = 1'b0;
    req1_valid = 1'b1; req1_idx = 1'b1;
    #1;
    n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL cfg_req1_ready_c1 got=%b want=1", req1_ready); end
    @(posedge CLK); #1;
    req1_valid = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL cfg_rsp_valid_c2 got=%b want=1", rsp_valid); end
    n_checks++; if (rsp_id !== 1'b1) begin n_fail++; $display("FAIL cfg_rsp_id_c2 got=%b want=1", rsp_id); end
    n_checks++; if (rsp_data !== 4'h9) begin n_fail++; $display("FAIL cfg_rsp_data_c2 got=%h want=9", rsp_data); end
  endtask

  task automatic test_back_to_back();
    logic       exp_id;
    logic [3:0] exp_data;
    cfg_valid = 1'b1; cfg_addr = 1'b0; cfg_data = 4'h6;
    #1;
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_setup_cfg_ready got=%b want=1", cfg_ready); end
    @(posedge CLK); #1;
    cfg_valid = 1'b0;
    req0_valid = 1'b1; req0_idx = 1'b0;
    req1_valid = 1'b1; req1_idx = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_id   = (i % 2 == 1);
      exp_data = exp_id ? 4'h9 : 4'h6;
      #1;
      n_checks++; if (req0_ready !== ~exp_id) begin n_fail++; $display("FAIL b2b_req0_ready[%0d] got=%b want=%b", i, req0_ready, ~exp_id); end
      n_checks++; if (req1_ready !== exp_id) begin n_fail++; $display("FAIL b2b_req1_ready[%0d] got=%b want=%b", i, req1_ready, exp_id); end
      @(posedge CLK); #1;
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rsp_valid[%0d] got=%b want=1", i, rsp_valid); end
      n_checks++; if (rsp_id !== exp_id) begin n_fail++; $display("FAIL b2b_rsp_id[%0d] got=%b want=%b", i, rsp_id, exp_id); end
      n_checks++; if (rsp_data !== exp_data) begin n_fail++; $display("FAIL b2b_rsp_data[%0d] got=%h want=%h", i, rsp_data, exp_data); end
    end
  endtask

  task automatic test_stall();
    rsp_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cfg_valid = (j == 1); cfg_addr = 1'b0; cfg_data = 4'hF;
      #1;
      n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got=%b%b want=00", j, req0_ready, req1_ready); end
      n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL stall_cfg_ready[%0d] got=%b want=0", j, cfg_ready); end
      @(posedge CLK); #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 4'h9) begin n_fail++; $display("FAIL stall_hold[%0d] got=v%b id%b d%h want=v1 id1 d9", j, rsp_valid, rsp_id, rsp_data); end
    end
    cfg_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL stall_release_ready got=%b%b want=10", req0_ready, req1_ready); end
    @(posedge CLK); #1;
    n_checks++; if (rsp_id !== 1'b0 || rsp_data !== 4'h6) begin n_fail++; $display("FAIL stall_release_rsp got=id%b d%h want=id0 d6", rsp_id, rsp_data); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge CLK); #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain_valid got=%b want=0", rsp_valid); end
  endtask

  task automatic test_cfg_priority();
    cfg_valid = 1'b1; cfg_addr = 1'b0; cfg_data = 4'hA;
    req0_valid = 1'b1; req0_idx = 1'b0;
    #1;
    n_checks++; if (cfg_ready !== 1'b1 || req0_ready !== 1'b0) begin n_fail++; $display("FAIL prio_c0 got=cfg%b r0%b want=cfg1 r00", cfg_ready, req0_ready); end
    @(posedge CLK); #1;
    cfg_valid = 1'b0;
    #1;
    n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL prio_c1_req0_ready got=%b want=1", req0_ready); end
    @(posedge CLK); #1;
    req0_valid = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 4'hA) begin n_fail++; $display("FAIL prio_rsp got=v%b id%b d%h want=v1 id0 dA", rsp_valid, rsp_id, rsp_data); end
    @(posedge CLK); #1;
  endtask

  task automatic test_async_reset();
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_idx = 1'b0;
    #1;
    n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL arst_req1_ready got=%b want=1", req1_ready); end
    @(posedge CLK); #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 4'hA) begin n_fail++; $display("FAIL arst_pre_rsp got=v%b id%b d%h want=v1 id1 dA", rsp_valid, rsp_id, rsp_data); end
    #1;
    ASYNCRESETN = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_drop got=v%b b%b want=v0 b0", rsp_valid, busy); end
    n_checks++; if (rsp_data !== 4'h0 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL arst_rsp_clear got=id%b d%h want=id0 d0", rsp_id, rsp_data); end
    n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL arst_req1_ready_low got=%b want=0", req1_ready); end
    req1_valid = 1'b0;
    #1;
    ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL arst_after_release got=b%b v%b want=b0 v0", busy, rsp_valid); end
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_idx = 1'b0;
    req1_valid = 1'b1; req1_idx = 1'b1;
    #1;
    n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL arst_tie_ready got=%b%b want=10", req0_ready, req1_ready); end
    @(posedge CLK); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 4'h0) begin n_fail++; $display("FAIL arst_table_cleared got=v%b id%b d%h want=v1 id0 d0", rsp_valid, rsp_id, rsp_data); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_first_lookup();
    test_cfg_then_lookup();
    test_back_to_back();
    test_stall();
    test_cfg_priority();
    test_async_reset();
    @(posedge CLK); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
